// File: rtl/pc_pkg.sv
// Shared types for the PC generator: FSM states, redirect-source encoding and default reset vector.
package pc_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h1C00_0000;
    localparam int unsigned PERF_CNT_W    = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EXC  = 2'd1,
        BR   = 2'd2,
        SEQ  = 2'd3
    } pc_src_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational next-pc select: exception > branch > sequential advance > hold.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              br_valid,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              advance,
    output pc_src_e           src_c,
    output logic [ADDR_W-1:0] next_pc_c
);

    // Sequential add wraps naturally at ADDR_W bits.
    always_comb begin
        src_c     = NONE;
        next_pc_c = pc;
        if (exc_valid) begin
            src_c     = EXC;
            next_pc_c = exc_target;
        end else if (br_valid && br_en) begin
            src_c     = BR;
            next_pc_c = br_target;
        end else if (advance) begin
            src_c     = SEQ;
            next_pc_c = pc + ADDR_W'(FETCH_BYTES);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BOOT/RUN/HALT control and redirect handling.
// Optional performance counters are built when PC_GEN_PERF_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
    parameter int unsigned       FETCH_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_ready,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              pc_misalign,
    output logic              redirected
`ifdef PC_GEN_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] redirect_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

    pc_state_e         state_q;
    pc_state_e         state_d;
    pc_src_e           src_c;
    logic [ADDR_W-1:0] next_pc_c;
    logic              advance_c;
    logic              br_en_c;
    logic              redirect_c;

    // A halt request freezes the pc instead of advancing it.
    assign advance_c  = pc_valid & fetch_ready & ~halt_req;
    assign br_en_c    = (state_q != HALT);
    assign redirect_c = (src_c == EXC) || (src_c == BR);

    pc_redirect_arb #(
        .ADDR_W      (ADDR_W),
        .FETCH_BYTES (FETCH_BYTES)
    ) u_arb (
        .pc         (pc),
        .exc_valid  (exc_valid),
        .exc_target (exc_target),
        .br_valid   (br_valid),
        .br_en      (br_en_c),
        .br_target  (br_target),
        .advance    (advance_c),
        .src_c      (src_c),
        .next_pc_c  (next_pc_c)
    );

    // Next-state logic; an exception always wins over a halt request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!exc_valid && halt_req) state_d = HALT;
            HALT:    if (exc_valid) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc          <= RESET_VEC;
            pc_valid    <= 1'b0;
            pc_misalign <= 1'b0;
            redirected  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc          <= next_pc_c;
            pc_valid    <= (state_d == RUN);
            pc_misalign <= |next_pc_c[1:0];
            redirected  <= redirect_c;
        end
    end

`ifdef PC_GEN_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redirect_c && (redirect_cnt != '1)) begin
                redirect_cnt <= redirect_cnt + PERF_CNT_W'(1);
            end
            if ((state_q == RUN) && !fetch_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a cycle model.
module tb_pc_gen;

    localparam int unsigned     AW = 32;
    localparam logic [AW-1:0]   RV = 32'h1C00_0000;
    localparam logic [AW-1:0]   FB = 32'd4;

    typedef enum int {M_BOOT, M_RUN, M_HALT} mstate_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_ready;
    logic          exc_valid;
    logic [AW-1:0] exc_target;
    logic          br_valid;
    logic [AW-1:0] br_target;
    logic          halt_req;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          pc_misalign;
    logic          redirected;
`ifdef PC_GEN_PERF_EN
    logic [31:0]   redirect_cnt;
    logic [31:0]   stall_cnt;
    logic [31:0]   m_rcnt;
    logic [31:0]   m_stall;
`endif

    int            n_vec = 0;
    int            n_bad = 0;
    mstate_t       m_state;
    logic [AW-1:0] m_pc;
    logic          m_redir;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_ready (fetch_ready),
        .exc_valid   (exc_valid),
        .exc_target  (exc_target),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_misalign (pc_misalign),
        .redirected  (redirected)
`ifdef PC_GEN_PERF_EN
        ,
        .redirect_cnt(redirect_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic idle();
        fetch_ready = 1'b0;
        exc_valid   = 1'b0;
        exc_target  = '0;
        br_valid    = 1'b0;
        br_target   = '0;
        halt_req    = 1'b0;
    endtask

    task automatic model_reset();
        m_state = M_BOOT;
        m_pc    = RV;
        m_redir = 1'b0;
`ifdef PC_GEN_PERF_EN
        m_rcnt  = 0;
        m_stall = 0;
`endif
    endtask

    // Advance the reference model by one edge from the current inputs, then clock the DUT.
    task automatic tick();
        bit live;
        live    = (m_state == M_RUN);
        m_redir = 1'b0;
        if (exc_valid) begin
            m_pc = exc_target; m_redir = 1'b1;
        end else if (br_valid && m_state != M_HALT) begin
            m_pc = br_target;  m_redir = 1'b1;
        end else if (live && fetch_ready && !halt_req) begin
            m_pc = m_pc + FB;
        end
`ifdef PC_GEN_PERF_EN
        if (m_redir && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
        if (live && !fetch_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
        case (m_state)
            M_BOOT: m_state = M_RUN;
            M_RUN:  if (!exc_valid && halt_req) m_state = M_HALT;
            M_HALT: if (exc_valid) m_state = M_RUN;
            default: m_state = M_BOOT;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_vec++; if (pc !== RV) begin n_bad++; $display("FAIL rst_pc got %h want %h", pc, RV); end
        n_vec++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", pc_valid); end
        n_vec++; if (pc_misalign !== 1'b0) begin n_bad++; $display("FAIL rst_misalign got %b want 0", pc_misalign); end
        n_vec++; if (redirected !== 1'b0) begin n_bad++; $display("FAIL rst_redir got %b want 0", redirected); end
`ifdef PC_GEN_PERF_EN
        n_vec++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
        n_vec++; if (redirect_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_rcnt got %0d want 0", redirect_cnt); end
`endif
    endtask

    task automatic test_sequential();
        model_reset();
        fetch_ready = 1'b1;
        rst_n = 1'b1;
        n_vec++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL boot_valid got %b want 0", pc_valid); end
        tick();
        n_vec++; if (pc !== 32'h1C00_0000 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL seq0 got %h/%b want 1c000000/1", pc, pc_valid); end
        tick();
        n_vec++; if (pc !== 32'h1C00_0004) begin n_bad++; $display("FAIL seq1 got %h want 1c000004", pc); end
        tick();
        n_vec++; if (pc !== 32'h1C00_0008) begin n_bad++; $display("FAIL seq2 got %h want 1c000008", pc); end
    endtask

    task automatic test_stall();
        tick(); tick();
        n_vec++; if (pc !== 32'h1C00_0010) begin n_bad++; $display("FAIL stall_start got %h want 1c000010", pc); end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (pc !== 32'h1C00_0010 || pc_valid !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold%0d got %h/%b want 1c000010/1", i, pc, pc_valid);
            end
        end
`ifdef PC_GEN_PERF_EN
        n_vec++; if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
`endif
    endtask

    task automatic test_exc_br_same();
        fetch_ready = 1'b0;
        exc_valid = 1'b1; exc_target = 32'h1C00_1000;
        br_valid  = 1'b1; br_target  = 32'h1C00_0800;
        tick();
        n_vec++; if (pc !== 32'h1C00_1000) begin n_bad++; $display("FAIL exc_win got %h want 1c001000", pc); end
        n_vec++; if (redirected !== 1'b1) begin n_bad++; $display("FAIL exc_redir got %b want 1", redirected); end
        idle();
        tick();
        n_vec++; if (redirected !== 1'b0 || pc !== 32'h1C00_1000) begin n_bad++; $display("FAIL exc_pulse got %b/%h want 0/1c001000", redirected, pc); end
    endtask

    task automatic test_halt();
        br_valid = 1'b1; br_target = 32'h1C00_0020;
        tick();
        idle(); fetch_ready = 1'b1; halt_req = 1'b1;
        tick();
        n_vec++; if (pc_valid !== 1'b0 || pc !== 32'h1C00_0020) begin n_bad++; $display("FAIL halt_enter got %b/%h want 0/1c000020", pc_valid, pc); end
        halt_req = 1'b0; br_valid = 1'b1; br_target = 32'h1C00_0900;
        tick();
        n_vec++; if (pc !== 32'h1C00_0020 || redirected !== 1'b0 || pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_br_ign got %h/%b/%b want 1c000020/0/0", pc, redirected, pc_valid);
        end
        br_valid = 1'b0; halt_req = 1'b1; exc_valid = 1'b1; exc_target = 32'h1C00_0040;
        tick();
        n_vec++; if (pc !== 32'h1C00_0040 || pc_valid !== 1'b1 || redirected !== 1'b1) begin
            n_bad++; $display("FAIL halt_wake got %h/%b/%b want 1c000040/1/1", pc, pc_valid, redirected);
        end
        idle(); fetch_ready = 1'b1;
        tick();
        n_vec++; if (pc !== 32'h1C00_0044) begin n_bad++; $display("FAIL wake_adv got %h want 1c000044", pc); end
    endtask

    task automatic test_misalign_wrap();
        br_valid = 1'b1; br_target = 32'h1C00_0002; halt_req = 1'b1;
        tick();
        n_vec++; if (pc !== 32'h1C00_0002 || pc_misalign !== 1'b1 || pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL br_halt_mis got %h/%b/%b want 1c000002/1/0", pc, pc_misalign, pc_valid);
        end
        idle(); exc_valid = 1'b1; exc_target = 32'hFFFF_FFFC;
        tick();
        idle(); fetch_ready = 1'b1;
        tick();
        n_vec++; if (pc !== 32'h0000_0000 || pc_misalign !== 1'b0) begin n_bad++; $display("FAIL wrap got %h/%b want 00000000/0", pc, pc_misalign); end
    endtask

    task automatic test_reset_mid();
        exc_valid = 1'b1; exc_target = 32'h1C00_0300;
        tick();
        n_vec++; if (redirected !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %b want 1", redirected); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (pc !== RV || redirected !== 1'b0 || pc_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst got %h/%b/%b want 1c000000/0/0", pc, redirected, pc_valid);
        end
        idle(); br_valid = 1'b1; br_target = 32'h1C00_0500;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vec++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL boot2_valid got %b want 0", pc_valid); end
        tick();
        n_vec++; if (pc !== 32'h1C00_0500 || pc_valid !== 1'b1 || redirected !== 1'b1) begin
            n_bad++; $display("FAIL boot_br got %h/%b/%b want 1c000500/1/1", pc, pc_valid, redirected);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            fetch_ready = ($urandom_range(3) != 0);
            exc_valid   = ($urandom_range(15) == 0);
            br_valid    = ($urandom_range(5) == 0);
            halt_req    = ($urandom_range(15) == 0);
            exc_target  = $urandom();
            br_target   = $urandom();
            if ($urandom_range(3) != 0) exc_target[1:0] = 2'b00;
            if ($urandom_range(3) != 0) br_target[1:0]  = 2'b00;
            tick();
            n_vec++; if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc c%0d got %h want %h", i, pc, m_pc); end
            n_vec++; if (pc_valid !== (m_state == M_RUN)) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", i, pc_valid, m_state == M_RUN); end
            n_vec++; if (pc_misalign !== (|m_pc[1:0])) begin n_bad++; $display("FAIL rnd_mis c%0d got %b want %b", i, pc_misalign, |m_pc[1:0]); end
            n_vec++; if (redirected !== m_redir) begin n_bad++; $display("FAIL rnd_redir c%0d got %b want %b", i, redirected, m_redir); end
`ifdef PC_GEN_PERF_EN
            n_vec++; if (stall_cnt !== m_stall) begin n_bad++; $display("FAIL rnd_stall c%0d got %0d want %0d", i, stall_cnt, m_stall); end
            n_vec++; if (redirect_cnt !== m_rcnt) begin n_bad++; $display("FAIL rnd_rcnt c%0d got %0d want %0d", i, redirect_cnt, m_rcnt); end
`endif
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_exc_br_same();
        test_halt();
        test_misalign_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h1C00_0000, first fetch address after reset.
REQ-003 SHALL have parameter FETCH_BYTES, default 4, sequential increment per accepted fetch (power of two, 4..16).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port fetch_ready  input  1  fetch stage accepts the current pc this cycle.
REQ-007 SHALL have port exc_valid / exc_target  input  1 / ADDR_W  exception or ertn redirect.
REQ-008 SHALL have port br_valid / br_target  input  1 / ADDR_W  branch mispredict redirect.
REQ-009 SHALL have port halt_req  input  1  idle request; fetching stops.
REQ-010 SHALL have port pc  output  ADDR_W  current fetch address.
REQ-011 SHALL have port pc_valid  output  1  pc is a live fetch request.
REQ-012 SHALL have port pc_misalign  output  1  pc not aligned to 4 bytes (ADEF source).
REQ-013 SHALL have port redirected  output  1  pulse: pc was loaded from a redirect on the previous edge.

Function
REQ-014 SHALL implement states BOOT, RUN, HALT.
REQ-015 BOOT: pc_valid=0; exactly one cycle after reset deassertion, then RUN.
REQ-016 RUN: pc_valid=1; advance = pc_valid & fetch_ready.
REQ-017 Next-pc priority: exc_valid > br_valid > advance (pc+FETCH_BYTES) > hold.
REQ-018 Redirects SHALL take effect on the next edge regardless of fetch_ready; no pending buffer, no lost redirect.
REQ-019 exc and br asserted in the same cycle: exc_target wins, br dropped.
REQ-020 Sequential addition SHALL wrap modulo 2^ADDR_W; no carry out.
REQ-021 Unaligned targets SHALL be loaded unmodified; pc_misalign = |pc[1:0], registered with pc.
REQ-022 halt_req in RUN, no redirect: go HALT, pc holds, pc_valid=0 next cycle.
REQ-023 halt_req with br_valid in the same cycle: load br_target, then HALT.
REQ-024 HALT: br_valid ignored; exc_valid loads exc_target and returns to RUN (wake-up); halt_req ignored while exc_valid.
REQ-025 redirected SHALL be 1 for exactly one cycle after any accepted redirect, else 0.
REQ-026 Redirects in BOOT SHALL be accepted (pc loaded), state still moves to RUN.

Reset
REQ-027 rst_n low SHALL asynchronously set pc=RESET_VEC, state=BOOT, pc_valid=0, pc_misalign=0, redirected=0.
REQ-028 Reset mid-operation SHALL discard any in-flight redirect and halt state.
REQ-029 No pre-decremented reset vector; first valid pc equals RESET_VEC.

Configuration
REQ-030 Macro PC_GEN_PERF_EN defined: add outputs redirect_cnt (32) and stall_cnt (32); redirect_cnt increments per accepted redirect, stall_cnt per RUN cycle with fetch_ready=0; both saturate at all-ones, reset to 0.
REQ-031 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package pc_pkg SHALL hold the state enum (BOOT/RUN/HALT), default RESET_VEC, and redirect-source encoding (NONE/EXC/BR/SEQ).
REQ-033 One sub-module pc_redirect_arb SHALL implement the combinational priority select of REQ-017; all state stays in pc_gen.

Verification
REQ-034 Reset release, fetch_ready=1 -> cycle1 pc_valid=0; then pc=1C000000, 1C000004, 1C000008.
REQ-035 fetch_ready=0 for 3 cycles at pc=1C000010 -> pc holds 1C000010, pc_valid=1 throughout, stall_cnt+=3 (PERF_EN).
REQ-036 exc_valid target=1C001000 and br_valid target=1C000800 same cycle, fetch_ready=0 -> next pc=1C001000, redirected=1 one cycle.
REQ-037 halt_req at pc=1C000020 -> pc_valid=0, pc holds; br_valid ignored; exc_valid target=1C000040 -> RUN, pc=1C000040.
REQ-038 br_target=1C000002 -> pc=1C000002, pc_misalign=1; ADDR_W=32, pc=FFFFFFFC advance -> pc=00000000.
REQ-039 rst_n asserted mid-redirect -> pc=1C000000 immediately, redirected=0, BOOT.
